// File: rtl/intersection_guard.sv
// intersection_guard: safety monitor between the traffic-light controller and the lamp drivers.
// Define GUARD_SEQ_CHECK_EN to compile in the phase-sequence check (fault code 4).
//
// state | meaning
// ------+-------------------------------------------------------------
// MON   | pass-through, lights_out follows lights_in one clock later
// PEND  | light violation seen, lights_out frozen while it is filtered
// FLASH | fault latched, fail-safe yellow/red flashing until cleared
module intersection_guard #(
    parameter int CYCLE_MAX  = 68,
    parameter int FAULT_HOLD = 2,
    parameter int FLASH_HALF = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] lights_in,
    input  logic [6:0]  current_cycle,
    input  logic        fault_clr,
    output logic [15:0] lights_out,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic        flash
);

    typedef enum logic [1:0] {
        ST_MON   = 2'd0,
        ST_PEND  = 2'd1,
        ST_FLASH = 2'd2
    } state_t;

    localparam logic [2:0]  CODE_NONE     = 3'd0;
    localparam logic [2:0]  CODE_CAR      = 3'd1;
    localparam logic [2:0]  CODE_PED      = 3'd2;
    localparam logic [2:0]  CODE_PED_ILL  = 3'd3;
    localparam logic [2:0]  CODE_SEQ      = 3'd4;
    localparam logic [4:0]  HOLD_LIMIT    = 5'(FAULT_HOLD);
    localparam logic [7:0]  FLASH_RELOAD  = 8'(FLASH_HALF - 1);
    localparam logic [15:0] FLASH_YELLOW  = 16'h8888;
    localparam logic [15:0] ALL_RED       = 16'h0000;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] lights_q;
    logic [2:0]  fault_code_q;
    logic        flash_q;
    logic [7:0]  flash_cnt;
    logic [3:0]  hold_cnt;
    logic [2:0]  light_code;
    logic        light_viol;
    logic        seq_err;
    logic        hold_done;
    logic        enter_flash;

    logic [1:0] n_car, n_ped, s_car, s_ped, e_car, e_ped, w_car, w_ped;
    assign {n_car, n_ped, s_car, s_ped, e_car, e_ped, w_car, w_ped} = lights_in;

    logic car_conflict;
    logic ped_conflict;
    logic ped_illegal;

    assign car_conflict = ((n_car != 2'b00) || (s_car != 2'b00)) &&
                          ((e_car != 2'b00) || (w_car != 2'b00));
    assign ped_conflict = ((n_car != 2'b00) && (n_ped != 2'b00)) ||
                          ((s_car != 2'b00) && (s_ped != 2'b00)) ||
                          ((e_car != 2'b00) && (e_ped != 2'b00)) ||
                          ((w_car != 2'b00) && (w_ped != 2'b00));
    assign ped_illegal  = (n_ped == 2'b11) || (s_ped == 2'b11) ||
                          (e_ped == 2'b11) || (w_ped == 2'b11);

    // Lowest code wins when several checks fail together.
    always_comb begin
        light_code = CODE_NONE;
        if (car_conflict) begin
            light_code = CODE_CAR;
        end else if (ped_conflict) begin
            light_code = CODE_PED;
        end else if (ped_illegal) begin
            light_code = CODE_PED_ILL;
        end
    end

    assign light_viol = (light_code != CODE_NONE);

`ifdef GUARD_SEQ_CHECK_EN
    localparam logic [6:0] CYCLE_LAST = 7'(CYCLE_MAX);

    logic [6:0] prev_cycle;
    logic       seq_armed;
    logic [6:0] expected_cycle;

    assign expected_cycle = (prev_cycle == CYCLE_LAST) ? 7'd1 : prev_cycle + 7'd1;
    assign seq_err = seq_armed &&
                     ((current_cycle == 7'd0) || (current_cycle > CYCLE_LAST) ||
                      (current_cycle != expected_cycle));

    // Disarmed while flashing so the first sample back in MON only reloads prev_cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_cycle <= 7'd0;
            seq_armed  <= 1'b0;
        end else begin
            prev_cycle <= current_cycle;
            seq_armed  <= (state != ST_FLASH);
        end
    end
`else
    logic unused_cycle;
    assign unused_cycle = ^current_cycle;
    assign seq_err      = 1'b0;
`endif

    assign hold_done = ({1'b0, hold_cnt} + 5'd1) >= HOLD_LIMIT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_MON;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_MON: begin
                if (light_viol) begin
                    state_nxt = (FAULT_HOLD <= 1) ? ST_FLASH : ST_PEND;
                end else if (seq_err) begin
                    state_nxt = ST_FLASH;
                end
            end
            ST_PEND: begin
                if (light_viol) begin
                    state_nxt = hold_done ? ST_FLASH : ST_PEND;
                end else if (seq_err) begin
                    state_nxt = ST_FLASH;
                end else begin
                    state_nxt = ST_MON;
                end
            end
            ST_FLASH: begin
                if (fault_clr && !light_viol) begin
                    state_nxt = ST_MON;
                end
            end
            default: state_nxt = ST_MON;
        endcase
    end

    assign enter_flash = (state != ST_FLASH) && (state_nxt == ST_FLASH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lights_q     <= ALL_RED;
            fault_code_q <= CODE_NONE;
            flash_q      <= 1'b0;
            flash_cnt    <= 8'd0;
            hold_cnt     <= 4'd0;
        end else if (enter_flash) begin
            fault_code_q <= light_viol ? light_code : CODE_SEQ;
            flash_q      <= 1'b1;
            flash_cnt    <= FLASH_RELOAD;
            hold_cnt     <= 4'd0;
        end else begin
            case (state)
                ST_MON: begin
                    if (light_viol) begin
                        hold_cnt <= 4'd1;
                    end else begin
                        lights_q <= lights_in;
                    end
                end
                ST_PEND: begin
                    if (light_viol) begin
                        hold_cnt <= hold_cnt + 4'd1;
                    end else begin
                        hold_cnt <= 4'd0;
                        lights_q <= lights_in;
                    end
                end
                ST_FLASH: begin
                    if (state_nxt == ST_MON) begin
                        fault_code_q <= CODE_NONE;
                        flash_q      <= 1'b0;
                        flash_cnt    <= 8'd0;
                        lights_q     <= lights_in;
                    end else if (flash_cnt == 8'd0) begin
                        flash_q   <= ~flash_q;
                        flash_cnt <= FLASH_RELOAD;
                    end else begin
                        flash_cnt <= flash_cnt - 8'd1;
                    end
                end
                default: begin
                    hold_cnt <= 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        lights_out = lights_q;
        fault      = 1'b0;
        if (state == ST_FLASH) begin
            lights_out = flash_q ? FLASH_YELLOW : ALL_RED;
            fault      = 1'b1;
        end
    end

    assign fault_code = fault_code_q;
    assign flash      = flash_q;

endmodule

// File: tb/tb_intersection_guard.sv
// Self-checking bench for intersection_guard: directed scenarios plus a random run,
// all compared against an abstract model of the guard's rules.
`timescale 1ns/1ps
module tb_intersection_guard;

    localparam int CYCLE_MAX  = 68;
    localparam int FAULT_HOLD = 2;
    localparam int FLASH_HALF = 4;
`ifdef GUARD_SEQ_CHECK_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] lights_in = 16'h0000;
    logic [6:0]  current_cycle = 7'd0;
    logic        fault_clr = 1'b0;
    logic [15:0] lights_out;
    logic        fault;
    logic [2:0]  fault_code;
    logic        flash;
    logic [20:0] got;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_shown;
    bit          m_in_flash;
    int          m_age;
    int          m_code;
    int          m_run;
    bit          m_armed;
    int          m_prev;
    int          cc_now;

    intersection_guard #(
        .CYCLE_MAX (CYCLE_MAX),
        .FAULT_HOLD(FAULT_HOLD),
        .FLASH_HALF(FLASH_HALF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lights_in    (lights_in),
        .current_cycle(current_cycle),
        .fault_clr    (fault_clr),
        .lights_out   (lights_out),
        .fault        (fault),
        .fault_code   (fault_code),
        .flash        (flash)
    );

    always #5 clk = ~clk;

    assign got = {lights_out, fault, fault_code, flash};

    function automatic int light_code_of(input logic [15:0] li);
        logic [1:0] car[4];
        logic [1:0] ped[4];
        for (int i = 0; i < 4; i++) begin
            car[i] = li[15-4*i -: 2];
            ped[i] = li[13-4*i -: 2];
        end
        if ((car[0] != 0 || car[1] != 0) && (car[2] != 0 || car[3] != 0)) return 1;
        for (int i = 0; i < 4; i++) if (car[i] != 0 && ped[i] != 0) return 2;
        for (int i = 0; i < 4; i++) if (ped[i] == 2'b11) return 3;
        return 0;
    endfunction

    function automatic logic [20:0] model_out();
        bit          yel;
        logic [15:0] lo;
        yel = m_in_flash && (((m_age / FLASH_HALF) % 2) == 0);
        lo  = m_in_flash ? (yel ? 16'h8888 : 16'h0000) : m_shown;
        return {lo, m_in_flash, 3'(m_code), yel};
    endfunction

    task automatic model_reset();
        m_shown = 16'h0000; m_in_flash = 0; m_age = 0; m_code = 0;
        m_run = 0; m_armed = 0; m_prev = 0;
    endtask

    task automatic model_enter(input int c);
        m_in_flash = 1; m_age = 0; m_code = c; m_run = 0;
    endtask

    task automatic model_step(input logic [15:0] li, input int cc, input bit clr);
        int c;
        bit seq_bad;
        c = light_code_of(li);
        if (m_in_flash) begin
            m_armed = 0;
            if (clr && c == 0) begin
                m_in_flash = 0; m_code = 0; m_shown = li; m_run = 0;
            end else begin
                m_age++;
            end
        end else begin
            seq_bad = SEQ_ON && m_armed &&
                      (cc < 1 || cc > CYCLE_MAX || cc != ((m_prev == CYCLE_MAX) ? 1 : m_prev + 1));
            m_prev  = cc;
            m_armed = 1;
            if (c != 0) begin
                m_run++;
                if (m_run >= FAULT_HOLD) model_enter(c);
            end else begin
                m_run = 0;
                if (seq_bad) model_enter(4);
                else m_shown = li;
            end
        end
    endtask

    function automatic logic [15:0] clean_pat();
        logic [15:0] r;
        logic [1:0]  car, ped;
        bit          ns;
        r  = 16'h0000;
        ns = 1'($urandom_range(0, 1));
        for (int i = 0; i < 4; i++) begin
            if ((i < 2) == ns) begin
                car = 2'($urandom_range(0, 3)); ped = 2'b00;
            end else begin
                car = 2'b00; ped = 2'($urandom_range(0, 2));
            end
            r = {r[11:0], car, ped};
        end
        return r;
    endfunction

    task automatic step(input logic [15:0] li, input int cc, input bit clr);
        lights_in     = li;
        current_cycle = 7'(cc);
        fault_clr     = clr;
        @(posedge clk);
        model_step(li, cc, clr);
        #1;
    endtask

    task automatic next_cc();
        cc_now = (cc_now >= CYCLE_MAX) ? 1 : cc_now + 1;
    endtask

    task automatic step_clean(input bit clr);
        next_cc();
        step(clean_pat(), cc_now, clr);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (got !== 21'h0) begin
            n_fail++; $display("FAIL reset_state got=%h exp=%h", got, 21'h0);
        end
        #2 rst = 1'b0;
        model_reset();
        cc_now = 0;
    endtask

    task automatic test_normal();
        for (int i = 0; i < 2 * CYCLE_MAX; i++) begin
            step_clean(0);
            n_checks++;
            if (got !== model_out()) begin
                n_fail++; $display("FAIL normal i=%0d got=%h exp=%h", i, got, model_out());
            end
        end
    endtask

    task automatic test_glitch();
        step_clean(0);
        next_cc();
        step(16'h4040, cc_now, 0);
        n_checks++;
        if (got !== model_out() || fault !== 1'b0) begin
            n_fail++; $display("FAIL glitch_hold got=%h exp=%h", got, model_out());
        end
        for (int i = 0; i < 3; i++) begin
            step_clean(0);
            n_checks++;
            if (got !== model_out() || fault !== 1'b0) begin
                n_fail++; $display("FAIL glitch_resume i=%0d got=%h exp=%h", i, got, model_out());
            end
        end
    endtask

    task automatic test_car_conflict();
        for (int i = 0; i < 2; i++) begin
            next_cc();
            step(16'h4040, cc_now, 0);
        end
        n_checks++;
        if (fault !== 1'b1 || fault_code !== 3'd1 || flash !== 1'b1 || lights_out !== 16'h8888) begin
            n_fail++; $display("FAIL car_latch got=%h exp fault=1 code=1 flash=1 lights=8888", got);
        end
        for (int i = 1; i < 2 * FLASH_HALF + 2; i++) begin
            step_clean(0);
            n_checks++;
            if (got !== model_out()) begin
                n_fail++; $display("FAIL car_flash i=%0d got=%h exp=%h", i, got, model_out());
            end
        end
        step_clean(1);
        n_checks++;
        if (got !== model_out() || fault !== 1'b0) begin
            n_fail++; $display("FAIL car_clear got=%h exp=%h", got, model_out());
        end
    endtask

`ifdef GUARD_SEQ_CHECK_EN
    task automatic test_seq();
        for (int i = 0; i < 2 * CYCLE_MAX && cc_now != CYCLE_MAX; i++) step_clean(0);
        step_clean(0);
        n_checks++;
        if (fault !== 1'b0 || current_cycle !== 7'd1) begin
            n_fail++; $display("FAIL seq_wrap fault=%b cc=%0d exp fault=0 cc=1", fault, current_cycle);
        end
        for (int i = 0; i < 2 * CYCLE_MAX && cc_now != 10; i++) step_clean(0);
        cc_now = 12;
        step(clean_pat(), cc_now, 0);
        n_checks++;
        if (fault !== 1'b1 || fault_code !== 3'd4 || got !== model_out()) begin
            n_fail++; $display("FAIL seq_skip got=%h exp=%h", got, model_out());
        end
        step_clean(1);
        cc_now = 40;
        step(clean_pat(), cc_now, 0);
        n_checks++;
        if (got !== model_out() || fault !== 1'b0) begin
            n_fail++; $display("FAIL seq_rearm got=%h exp=%h", got, model_out());
        end
    endtask
`endif

    task automatic test_clear();
        for (int i = 0; i < 2; i++) begin
            next_cc();
            step(16'h0030, cc_now, 0);
        end
        next_cc();
        step(16'h0030, cc_now, 1);
        n_checks++;
        if (fault !== 1'b1 || fault_code !== 3'd3 || got !== model_out()) begin
            n_fail++; $display("FAIL clear_ignored got=%h exp=%h", got, model_out());
        end
        step_clean(1);
        n_checks++;
        if (fault !== 1'b0 || fault_code !== 3'd0 || got !== model_out()) begin
            n_fail++; $display("FAIL clear_ok got=%h exp=%h", got, model_out());
        end
        cc_now = $urandom_range(1, CYCLE_MAX);
        step(clean_pat(), cc_now, 0);
        n_checks++;
        if (fault !== 1'b0 || got !== model_out()) begin
            n_fail++; $display("FAIL clear_no_seq got=%h exp=%h", got, model_out());
        end
    endtask

    task automatic test_reset_mid_flash();
        for (int i = 0; i < 2; i++) begin
            next_cc();
            step(16'h4040, cc_now, 0);
        end
        step_clean(0);
        rst = 1'b1;
        #1;
        n_checks++;
        if (got !== 21'h0) begin
            n_fail++; $display("FAIL reset_mid_flash got=%h exp=%h", got, 21'h0);
        end
        model_reset();
        cc_now = 0;
        #2 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step_clean(0);
            n_checks++;
            if (got !== model_out()) begin
                n_fail++; $display("FAIL reset_resume i=%0d got=%h exp=%h", i, got, model_out());
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] li;
        bit          clr;
        for (int i = 0; i < 600; i++) begin
            li  = ($urandom_range(0, 99) < 75) ? clean_pat() : 16'($urandom());
            clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 29) == 0) cc_now = $urandom_range(0, 127);
            else next_cc();
            step(li, cc_now, clr);
            n_checks++;
            if (got !== model_out()) begin
                n_fail++; $display("FAIL random i=%0d in=%h got=%h exp=%h", i, li, got, model_out());
            end
        end
    endtask

    initial begin
        model_reset();
        cc_now = 0;
        test_reset();
        test_normal();
        test_glitch();
        test_car_conflict();
`ifdef GUARD_SEQ_CHECK_EN
        test_seq();
`endif
        test_clear();
        test_reset_mid_flash();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/intersection_guard.md
# intersection_guard

Safety monitor placed directly downstream of the four-approach traffic-light controller. Each clock it samples the eight 2-bit light codes and the shared phase counter. When it detects a conflicting or illegal light state, or a broken phase sequence, it latches a fault and drives the intersection into fail-safe flashing. In fault-free operation it passes the light codes through with one clock of latency to the lamp drivers.

## Interface
- `CYCLE_MAX`, default 68: last phase value. The phase counter runs 1..CYCLE_MAX and then wraps to 1.
- `FAULT_HOLD`, default 2: number of consecutive violating samples (range 1..15) needed to latch a light fault.
- `FLASH_HALF`, default 4: number of clocks in each half of the fail-safe flash period (range 1..255).
- `clk`  in  1: the single clock. All state changes on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `lights_in`  in  16: packed as {n_car, n_ped, s_car, s_ped, e_car, e_ped, w_car, w_ped}.
  - Car codes: 00 red, 01 green, 10 yellow, 11 left.
  - Pedestrian codes: 00 red, 01 green, 10 blink.
- `current_cycle`  in  7: phase counter from the controller.
- `fault_clr`  in  1: single-clock request to leave fail-safe mode.
- `lights_out`  out  16: guarded light codes, packed the same way as `lights_in`.
- `fault`  out  1: high while in FLASH.
- `fault_code`  out  3: cause of the latched fault. 0 none, 1 car conflict, 2 pedestrian conflict, 3 illegal pedestrian code, 4 phase sequence error.
- `flash`  out  1: current flash phase. 1 = yellow half.

## Operation
- Violation checks, evaluated combinationally on the inputs:
  - Car conflict: any N/S car code is non-red while any E/W car code is non-red.
  - Pedestrian conflict: on any approach, the car code is non-red while that approach's pedestrian code is non-red.
  - Illegal pedestrian code: any pedestrian code equals 11.
  - Phase sequence error: `current_cycle` is outside 1..CYCLE_MAX, or it differs from prev+1 (or from 1 when prev == CYCLE_MAX).
- If several checks fail in the same sample, the lowest fault code wins.
- Phase check arming: the phase check is disarmed on the first sample after reset and on the first sample after leaving FLASH. Those samples only load `prev`.
- FSM states: MON, PEND, FLASH.
  - MON: `lights_out` is loaded with `lights_in` each clock.
    - A light violation (codes 1–3) loads the hold counter with 1. If FAULT_HOLD == 1, go to FLASH; otherwise go to PEND.
    - A phase sequence error goes to FLASH immediately.
  - PEND: `lights_out` is frozen.
    - While the violation persists, the hold counter increments. When it reaches FAULT_HOLD, go to FLASH.
    - A clean sample returns to MON and loads `lights_out` from that clean sample.
  - FLASH:
    - Pedestrian fields are 00. Car fields are 10 during the yellow half and 00 during the red half.
    - The flash counter starts in the yellow half on entry and toggles halves every FLASH_HALF clocks.
    - `fault_code` is frozen at the cause captured on entry.
  - FLASH exit: `fault_clr` is sampled high AND the same sample shows no light violation. The block then returns to MON, clears `fault_code` to 0, and disarms the phase check for one sample.
  - If `fault_clr` is high while a violation is present, it is ignored.
- Reset (at any time, including mid-FLASH or mid-PEND):
  - State MON; `lights_out` = 16'h0000 (all red).
  - `fault` = 0, `fault_code` = 0, `flash` = 0.
  - Hold counter and flash counter cleared; phase check disarmed.

## Timing
- Pass-through latency is 1 clock: a value sampled at edge k appears on `lights_out` after edge k.
- Light fault: first violating sample at edge k, FAULT_HOLD = 2, violation persists at edge k+1. Then `fault` = 1, `flash` = 1 and car fields = 10 after edge k+1.
- Phase sequence error sampled at edge k: `fault` = 1 after edge k.
- Flash waveform: yellow for FLASH_HALF clocks, then red for FLASH_HALF clocks, repeating for as long as the block stays in FLASH.
- A valid `fault_clr` sampled at edge k: MON is active after edge k, and `lights_out` = `lights_in` sampled at edge k.

## Configuration
- `GUARD_SEQ_CHECK_EN`:
  - Defined: the phase sequence check and fault code 4 are compiled in.
  - Undefined: `current_cycle` is ignored, `prev` logic is removed, and code 4 is never produced.
  - Checks 1–3 are identical in both cases.

## Test plan
- Normal run: reset, then the controller's nominal sequence for 2×68 clocks. Required: `fault` stays 0, and `lights_out` equals `lights_in` delayed by 1 clock at every edge.
- Glitch filtering: n_car = 01 and e_car = 01 for exactly 1 clock. Required: `lights_out` holds its previous value for 1 clock and then resumes pass-through; `fault` stays 0.
- Latched car conflict: the same stimulus held for 2 clocks. Required: `fault` = 1 and `fault_code` = 1 after the second edge. All car fields = 10 for 4 clocks, then 00 for 4 clocks. All pedestrian fields = 00.
- Phase sequence error (macro defined): `current_cycle` goes 10 → 12. Required: `fault` = 1 and `fault_code` = 4 after the edge that samples 12. Also check the wrap: 68 → 1 gives no fault.
- Clear handling:
  - `fault_clr` pulsed while e_ped = 11. Required: remains in FLASH with `fault_code` = 3.
  - `fault_clr` pulsed with clean inputs. Required: MON after that edge, `fault_code` = 0, and no code-4 fault on the next sample.
- Reset mid-FLASH: assert `rst` between edges. Required: immediately `lights_out` = 16'h0000 and `fault`, `fault_code`, `flash` = 0; pass-through resumes after `rst` is released.
